vliw_scoreboard: RTL and testbench

- Parametrised issue/retire scoreboard for the VLIW core.
- Sits between decode and the functional-unit lanes (adder, multiplier, FPA, FPM, logic unit, memory unit).
- Tracks in-flight destination registers against each lane's fixed pipeline latency.
- Stalls a bundle on RAW/WAW hazards and emits per-lane write-back strobes with destination indices, replacing the per-unit hard-coded tag delay lines.

---
 rtl/vliw_scoreboard.sv | 128 ++++++++++++
 tb/tb_vliw_scoreboard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_scoreboard.sv
// Issue/retire scoreboard: tracks pending destinations per lane latency, stalls RAW/WAW bundles.
// Latency: wb strobe in the cycle after edge t0+LAT-1; issue_ready is combinational, bundles all-or-nothing.
module vliw_scoreboard #(
    parameter int                         LANES   = 6,
    parameter int                         REGS    = 32,
    parameter int                         AW      = 5,
    parameter int                         LAT_W   = 5,
    parameter logic [LANES*LAT_W-1:0]     LAT_VEC = {5'd1, 5'd1, 5'd25, 5'd4, 5'd13, 5'd4},
    parameter int                         STALL_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        issue_valid,
    input  logic [LANES*AW-1:0]     issue_dst,
    input  logic [2*LANES*AW-1:0]   issue_src,
    input  logic                    flush,
    output logic                    issue_ready,
    output logic [LANES-1:0]        wb_valid,
    output logic [LANES*AW-1:0]     wb_dst,
    output logic [REGS-1:0]         busy,
    output logic [STALL_W-1:0]      stall_cnt
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LAT_W-1:0] cnt    [REGS];
    logic [LW-1:0]    laneOf [REGS];

    logic             hazard;
    logic             accept;
    logic [AW-1:0]    srcA, srcB, dstA, dstB;

    logic [REGS-1:0]  loadEn;
    logic [LAT_W-1:0] loadVal  [REGS];
    logic [LW-1:0]    loadLane [REGS];

    always_comb begin
        for (int r = 0; r < REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        hazard = 1'b0;
        srcA   = '0;
        srcB   = '0;
        dstA   = '0;
        dstB   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (issue_valid[l]) begin
                srcA = issue_src[2*l*AW +: AW];
                srcB = issue_src[(2*l+1)*AW +: AW];
                dstA = issue_dst[l*AW +: AW];
                if (srcA != '0 && busy[srcA]) hazard = 1'b1;
                if (srcB != '0 && busy[srcB]) hazard = 1'b1;
                if (dstA != '0 && busy[dstA]) hazard = 1'b1;
                // Two lanes in one bundle may not target the same register.
                for (int m = l + 1; m < LANES; m++) begin
                    dstB = issue_dst[m*AW +: AW];
                    if (issue_valid[m] && dstA != '0 && dstB == dstA) hazard = 1'b1;
                end
            end
        end
    end

    assign issue_ready = !hazard;
    assign accept      = issue_ready && (|issue_valid) && !flush;

    always_comb begin
        loadEn = '0;
        for (int r = 0; r < REGS; r++) begin
            loadVal[r]  = '0;
            loadLane[r] = '0;
        end
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (issue_valid[l] && issue_dst[l*AW +: AW] != '0) begin
                    loadEn[issue_dst[l*AW +: AW]]   = 1'b1;
                    loadVal[issue_dst[l*AW +: AW]]  = LAT_VEC[l*LAT_W +: LAT_W];
                    loadLane[issue_dst[l*AW +: AW]] = LW'(l);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REGS; r++) begin
                cnt[r]    <= '0;
                laneOf[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REGS; r++) begin
                if (loadEn[r]) begin
                    cnt[r]    <= loadVal[r];
                    laneOf[r] <= loadLane[r];
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Fixed per-lane latency means at most one register per lane hits 1 in a cycle.
    always_comb begin
        wb_valid = '0;
        wb_dst   = '0;
        for (int r = 1; r < REGS; r++) begin
            if (cnt[r] == LAT_W'(1)) begin
                wb_valid[laneOf[r]]         = 1'b1;
                wb_dst[laneOf[r]*AW +: AW]  = AW'(r);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((|issue_valid) && !issue_ready && !flush && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed bench for vliw_scoreboard: reset, latency, RAW/WAW stalls, R0, concurrent retire, flush, reset.
module tb_vliw_scoreboard;

    logic        clk;
    logic        rst;
    logic [5:0]  issue_valid;
    logic [29:0] issue_dst;
    logic [59:0] issue_src;
    logic        flush;
    logic        issue_ready;
    logic [5:0]  wb_valid;
    logic [29:0] wb_dst;
    logic [31:0] busy;
    logic [15:0] stall_cnt;

    int passCnt  = 0;
    int totalCnt = 0;

    vliw_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_src   (issue_src),
        .flush       (flush),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearBundle();
        issue_valid = '0;
        issue_dst   = '0;
        issue_src   = '0;
    endtask

    task automatic setLane(input int l, input logic [4:0] d, input logic [4:0] s0, input logic [4:0] s1);
        issue_valid[l]             = 1'b1;
        issue_dst[l*5 +: 5]        = d;
        issue_src[2*l*5 +: 5]      = s0;
        issue_src[(2*l+1)*5 +: 5]  = s1;
    endtask

    task automatic doReset();
        clearBundle();
        flush = 1'b0;
        rst   = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clearBundle();
        flush = 1'b0;
        rst   = 1'b0;
        #1;
        totalCnt++;
        if (busy !== 32'h0) $display("FAIL reset_busy: got %h want 0", busy); else passCnt++;
        totalCnt++;
        if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", issue_ready); else passCnt++;
        tick();
        rst = 1'b1;
        tick();
        totalCnt++;
        if (wb_valid !== 6'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else passCnt++;
        totalCnt++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else passCnt++;
        totalCnt++;
        if (issue_ready !== 1'b1 || busy !== 32'h0) $display("FAIL post_reset_idle: ready %b busy %h want 1/0", issue_ready, busy); else passCnt++;
    endtask

    task automatic test_single_add();
        doReset();
        setLane(0, 5'd5, 5'd0, 5'd0);
        tick();                       // edge 0
        clearBundle();
        totalCnt++;
        if (busy !== 32'h0000_0020) $display("FAIL add_busy_e0: got %h want 00000020", busy); else passCnt++;
        tick(); tick();               // edges 1, 2
        totalCnt++;
        if (wb_valid !== 6'b0) $display("FAIL add_no_early_wb: got %b want 0", wb_valid); else passCnt++;
        tick();                       // edge 3
        totalCnt++;
        if (wb_valid !== 6'b000001 || wb_dst !== 30'd5) $display("FAIL add_wb_e3: valid %b dst %h want 000001/5", wb_valid, wb_dst); else passCnt++;
        totalCnt++;
        if (busy !== 32'h0000_0020) $display("FAIL add_busy_at_retire: got %h want 00000020", busy); else passCnt++;
        tick();                       // edge 4
        totalCnt++;
        if (busy !== 32'h0 || wb_valid !== 6'b0) $display("FAIL add_clear_e4: busy %h wb %b want 0/0", busy, wb_valid); else passCnt++;
    endtask

    task automatic test_raw_stall();
        int stalls;
        logic sawWb;
        doReset();
        setLane(1, 5'd7, 5'd0, 5'd0);
        tick();                       // edge 0
        clearBundle();
        setLane(4, 5'd8, 5'd7, 5'd0);
        stalls = 0;
        sawWb  = 1'b0;
        while (!issue_ready && stalls < 40) begin
            if (stalls == 12) sawWb = (wb_valid === 6'b000010) && (wb_dst[9:5] === 5'd7);
            tick();
            stalls++;
        end
        totalCnt++;
        if (stalls !== 13) $display("FAIL raw_stall_cycles: got %0d want 13", stalls); else passCnt++;
        totalCnt++;
        if (!sawWb) $display("FAIL raw_mul_wb: got no lane1 wb of r7 after edge 12, want one"); else passCnt++;
        tick();                       // edge 14, accepted
        clearBundle();
        totalCnt++;
        if (busy !== 32'h0000_0100) $display("FAIL raw_accept_busy: got %h want 00000100", busy); else passCnt++;
        totalCnt++;
        if (stall_cnt !== 16'd13) $display("FAIL raw_stall_cnt: got %0d want 13", stall_cnt); else passCnt++;
        tick();
    endtask

    task automatic test_waw_r0();
        bit sawLane0;
        doReset();
        setLane(0, 5'd9, 5'd0, 5'd0);
        setLane(2, 5'd9, 5'd0, 5'd0);
        #1;
        totalCnt++;
        if (issue_ready !== 1'b0) $display("FAIL intra_waw: ready %b want 0", issue_ready); else passCnt++;
        clearBundle();
        setLane(1, 5'd7, 5'd0, 5'd0);
        setLane(3, 5'd12, 5'd0, 5'd0);
        tick();
        clearBundle();
        setLane(0, 5'd7, 5'd0, 5'd0);
        #1;
        totalCnt++;
        if (issue_ready !== 1'b0) $display("FAIL busy_waw: ready %b want 0", issue_ready); else passCnt++;
        clearBundle();
        setLane(0, 5'd1, 5'd0, 5'd12);
        #1;
        totalCnt++;
        if (issue_ready !== 1'b0) $display("FAIL busy_raw_src1: ready %b want 0", issue_ready); else passCnt++;
        clearBundle();
        setLane(0, 5'd0, 5'd0, 5'd0);
        #1;
        totalCnt++;
        if (issue_ready !== 1'b1) $display("FAIL r0_ready: ready %b want 1", issue_ready); else passCnt++;
        tick();
        clearBundle();
        sawLane0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (wb_valid[0] === 1'b1) sawLane0 = 1'b1;
            tick();
        end
        totalCnt++;
        if (sawLane0 || busy[0] !== 1'b0) $display("FAIL r0_no_wb: wb seen %b busy0 %b want 0/0", sawLane0, busy[0]); else passCnt++;
    endtask

    task automatic test_concurrent_retire();
        doReset();
        setLane(4, 5'd3, 5'd0, 5'd0);
        setLane(5, 5'd4, 5'd0, 5'd0);
        tick();
        clearBundle();
        totalCnt++;
        if (wb_valid !== 6'b110000) $display("FAIL conc_wb_valid: got %b want 110000", wb_valid); else passCnt++;
        totalCnt++;
        if (wb_dst[24:20] !== 5'd3 || wb_dst[29:25] !== 5'd4 || wb_dst[19:0] !== 20'd0)
            $display("FAIL conc_wb_dst: got %h want 3 on lane4, 4 on lane5", wb_dst);
        else passCnt++;
        tick();
        totalCnt++;
        if (wb_valid !== 6'b0 || busy !== 32'h0) $display("FAIL conc_after: wb %b busy %h want 0/0", wb_valid, busy); else passCnt++;
    endtask

    task automatic test_flush();
        bit sawWb;
        doReset();
        setLane(3, 5'd12, 5'd0, 5'd0);
        tick();                       // edge 0
        clearBundle();
        for (int i = 1; i < 9; i++) tick();
        setLane(4, 5'd3, 5'd0, 5'd0);
        tick();                       // edge 9, lane4 accepted
        clearBundle();
        setLane(0, 5'd20, 5'd0, 5'd0);
        flush = 1'b1;
        #1;
        totalCnt++;
        if (wb_valid !== 6'b010000) $display("FAIL flush_cycle_wb: got %b want 010000", wb_valid); else passCnt++;
        tick();                       // edge 10, flush
        flush = 1'b0;
        clearBundle();
        totalCnt++;
        if (busy !== 32'h0 || wb_valid !== 6'b0) $display("FAIL flush_clear: busy %h wb %b want 0/0", busy, wb_valid); else passCnt++;
        sawWb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wb_valid !== 6'b0) sawWb = 1'b1;
            tick();
        end
        totalCnt++;
        if (sawWb || stall_cnt !== 16'd0) $display("FAIL flush_no_wb: wb seen %b stall_cnt %0d want 0/0", sawWb, stall_cnt); else passCnt++;
    endtask

    task automatic test_reset_midop();
        bit sawWb;
        doReset();
        setLane(3, 5'd12, 5'd0, 5'd0);
        tick();
        clearBundle();
        for (int i = 1; i < 10; i++) tick();
        rst = 1'b0;
        #1;
        totalCnt++;
        if (busy !== 32'h0 || wb_valid !== 6'b0) $display("FAIL rst_midop_clear: busy %h wb %b want 0/0", busy, wb_valid); else passCnt++;
        tick();
        rst = 1'b1;
        sawWb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wb_valid !== 6'b0) sawWb = 1'b1;
            tick();
        end
        totalCnt++;
        if (sawWb) $display("FAIL rst_midop_no_wb: wb seen %b want 0", sawWb); else passCnt++;
    endtask

    initial begin
        clearBundle();
        flush = 1'b0;
        rst   = 1'b1;
        test_reset();
        test_single_add();
        test_raw_stall();
        test_waw_r0();
        test_concurrent_retire();
        test_flush();
        test_reset_midop();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
